wb_addr_decode: RTL and testbench
=================================

# wb_addr_decode

Wishbone B4 address-window decoder for the EconoPET FPGA system bus. Compares the upper bits of the bus address against a fixed base, reports whether the current address falls in this peripheral's window, and exposes the in-window offset. Also provides a qualified request and a registered single-cycle acknowledge, so a peripheral such as the CRTC register file completes zero-wait-state transactions. One instance sits in front of each Wishbone peripheral.

## Interface
Parameters:
- `WB_ADDR_WIDTH`, default 20: width of the Wishbone address.
- `REGION_WIDTH`, default 5: log2 of window size; low bits form the offset (1..WB_ADDR_WIDTH-1).
- `BASE`, default 0: window base address, WB_ADDR_WIDTH bits; only bits [WB_ADDR_WIDTH-1:REGION_WIDTH] are used, low bits ignored.

Ports:
- `wb_clock_i`  in  1  FPGA system clock.
- `wb_reset_i`  in  1  Reset; one clock, synchronous, active-high.
- `wb_addr_i`  in  WB_ADDR_WIDTH  bus address.
- `wb_cycle_i`  in  1  bus cycle active.
- `wb_strobe_i`  in  1  transfer requested.
- `selected_o`  out  1  address lies in window (combinational).
- `offset_o`  out  REGION_WIDTH  wb_addr_i[REGION_WIDTH-1:0] (combinational).
- `request_o`  out  1  selected_o & wb_cycle_i & wb_strobe_i (combinational).
- `stall_o`  out  1  constant 0; never stalls.
- `ack_o`  out  1  registered acknowledge.

## Operation
- Match: selected_o = (wb_addr_i[WB_ADDR_WIDTH-1:REGION_WIDTH] == BASE[WB_ADDR_WIDTH-1:REGION_WIDTH]). Pure compare; unaffected by reset, cycle or strobe.
- Window is [BASE_aligned, BASE_aligned + 2^REGION_WIDTH - 1], inclusive both ends; BASE_aligned = BASE with low REGION_WIDTH bits cleared.
- offset_o passes the low address bits unconditionally, valid regardless of match.
- request_o asserts only when address matches and both cycle and strobe are high.
- ack_o: each clock, ack_o <= request_o & ~wb_reset_i. Every accepted request yields exactly one ack pulse the following cycle; back-to-back requests yield back-to-back acks.
- stall_o tied low; each strobe is accepted in the cycle presented.
- Decoders for distinct peripherals with non-overlapping bases must never assert selected_o simultaneously.
- Elaboration-time check: REGION_WIDTH < WB_ADDR_WIDTH; otherwise a fatal error.

## Timing
- selected_o, offset_o, request_o: zero latency, combinational from inputs.
- ack_o: one cycle after request_o; single register.
- Reset: ack_o = 0 in the cycle after wb_reset_i is sampled high, held 0 while reset high. A request coinciding with reset is dropped (no ack). Combinational outputs continue to follow inputs during reset.
- Power-up (before reset) ack_o initialises to 0.
- Cycle dropped mid-transfer: no new request; an ack already registered still pulses for one cycle (peripheral/host ignores it per B4).
- Address change with strobe high each cycle: each cycle decoded independently; no state carried beyond ack_o.

## Test plan
- BASE=0x08000, REGION_WIDTH=5, WB_ADDR_WIDTH=20: addr 0x08000, 0x0801F -> selected_o=1, offset_o=0x00, 0x1F; addr 0x07FFF, 0x08020 -> selected_o=0.
- Same config, addr 0x08011, cycle=1, strobe=1 for one clock -> request_o=1 that cycle, ack_o=1 exactly next cycle, then 0.
- addr 0x08011 with cycle=1, strobe=0 (and cycle=0, strobe=1) -> request_o=0, ack_o stays 0.
- Strobe high 3 consecutive cycles at 0x08000, 0x08001, 0x09000 -> ack_o pattern 1,1,0 on the following three cycles.
- Assert wb_reset_i together with a matching request -> ack_o=0 next cycle; release reset, issue request -> ack_o=1 next cycle.
- BASE with low bits set (0x0801A), REGION_WIDTH=5 -> identical match behaviour to BASE=0x08000; stall_o=0 throughout all tests.

Source files
------------

// File: rtl/wb_addr_decode.sv
// wb_addr_decode: Wishbone B4 address-window decoder.
// Matches the upper address bits against a fixed base and reports the in-window
// offset combinationally. It also provides a qualified request and a registered
// single-cycle acknowledge, so the peripheral behind it completes every access
// with zero wait states.
module wb_addr_decode #(
  parameter int                       WB_ADDR_WIDTH = 20,
  parameter int                       REGION_WIDTH  = 5,
  parameter logic [WB_ADDR_WIDTH-1:0] BASE          = {WB_ADDR_WIDTH{1'b0}}
) (
  input  logic                     wb_clock_i,
  input  logic                     wb_reset_i,
  input  logic [WB_ADDR_WIDTH-1:0] wb_addr_i,
  input  logic                     wb_cycle_i,
  input  logic                     wb_strobe_i,
  output logic                     selected_o,
  output logic [REGION_WIDTH-1:0]  offset_o,
  output logic                     request_o,
  output logic                     stall_o,
  output logic                     ack_o
);

  // The upper address bits that select a window. The low REGION_WIDTH bits of
  // BASE are ignored, so the window is always aligned to its own size.
  localparam int TAG_WIDTH = WB_ADDR_WIDTH - REGION_WIDTH;
  localparam logic [TAG_WIDTH-1:0] BASE_TAG = BASE[WB_ADDR_WIDTH-1:REGION_WIDTH];

  // An out-of-range window size is a configuration error, so elaboration stops.
  if ((REGION_WIDTH < 1) || (REGION_WIDTH >= WB_ADDR_WIDTH)) begin : g_bad_region
    $fatal(1, "wb_addr_decode: REGION_WIDTH must be in 1..WB_ADDR_WIDTH-1");
  end

  // Compares the upper bits of an address with the window tag.
  function automatic logic addr_in_window(input logic [WB_ADDR_WIDTH-1:0] addr);
    return (addr[WB_ADDR_WIDTH-1:REGION_WIDTH] == BASE_TAG);
  endfunction

  logic selected_s;
  logic request_s;
  logic ack_d;
  // Power-up value. The flop must also read 0 before the first reset.
  logic ack_q = 1'b0;

  // Address decode and request qualification. These are purely combinational,
  // so they keep following the inputs while reset is asserted.
  always_comb begin
    selected_s = 1'b0;
    request_s  = 1'b0;
    if (addr_in_window(wb_addr_i)) begin
      selected_s = 1'b1;
      request_s  = wb_cycle_i & wb_strobe_i;
    end else begin
      selected_s = 1'b0;
      request_s  = 1'b0;
    end
  end

  // Next acknowledge. Every accepted request is answered on the following cycle.
  always_comb begin
    ack_d = 1'b0;
    if (request_s) begin
      ack_d = 1'b1;
    end else begin
      ack_d = 1'b0;
    end
  end

  // Acknowledge register. A request that arrives together with reset is dropped.
  always_ff @(posedge wb_clock_i) begin
    if (wb_reset_i) begin
      ack_q <= 1'b0;
    end else begin
      ack_q <= ack_d;
    end
  end

  assign selected_o = selected_s;
  assign offset_o   = wb_addr_i[REGION_WIDTH-1:0];
  assign request_o  = request_s;
  // Every strobe is accepted in the cycle it is presented, so stall is never raised.
  assign stall_o    = 1'b0;
  assign ack_o      = ack_q;

endmodule

// File: tb/tb_wb_addr_decode.sv
// Directed testbench for wb_addr_decode. It uses three decoders on one bus:
//   dut_a : BASE = 0x08000
//   dut_b : BASE = 0x0801A (low bits set, same window as dut_a)
//   dut_c : BASE = 0x08020 (neighbouring window)
module tb_wb_addr_decode;

  localparam int AW = 20;
  localparam int RW = 5;

  logic          clk;
  logic          rst;
  logic [AW-1:0] addr;
  logic          cyc;
  logic          stb;

  logic          sel_a, req_a, stall_a, ack_a;
  logic          sel_b, req_b, stall_b, ack_b;
  logic          sel_c, req_c, stall_c, ack_c;
  logic [RW-1:0] off_a, off_b, off_c;

  int n_checks;
  int n_fail;

  wb_addr_decode #(.WB_ADDR_WIDTH(AW), .REGION_WIDTH(RW), .BASE(20'h08000)) dut_a (
    .wb_clock_i(clk), .wb_reset_i(rst), .wb_addr_i(addr), .wb_cycle_i(cyc),
    .wb_strobe_i(stb), .selected_o(sel_a), .offset_o(off_a), .request_o(req_a),
    .stall_o(stall_a), .ack_o(ack_a)
  );

  wb_addr_decode #(.WB_ADDR_WIDTH(AW), .REGION_WIDTH(RW), .BASE(20'h0801A)) dut_b (
    .wb_clock_i(clk), .wb_reset_i(rst), .wb_addr_i(addr), .wb_cycle_i(cyc),
    .wb_strobe_i(stb), .selected_o(sel_b), .offset_o(off_b), .request_o(req_b),
    .stall_o(stall_b), .ack_o(ack_b)
  );

  wb_addr_decode #(.WB_ADDR_WIDTH(AW), .REGION_WIDTH(RW), .BASE(20'h08020)) dut_c (
    .wb_clock_i(clk), .wb_reset_i(rst), .wb_addr_i(addr), .wb_cycle_i(cyc),
    .wb_strobe_i(stb), .selected_o(sel_c), .offset_o(off_c), .request_o(req_c),
    .stall_o(stall_c), .ack_o(ack_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (got !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Waits for the next rising edge, then moves 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Checks the ack output of the two decoders that share the 0x08000 window.
  task automatic check_ack(input string tag, input logic exp);
    check({tag, "_ack_a"}, {31'd0, ack_a}, {31'd0, exp});
    check({tag, "_ack_b"}, {31'd0, ack_b}, {31'd0, exp});
    check({tag, "_ack_c"}, {31'd0, ack_c}, 32'd0);
    check({tag, "_stall"}, {29'd0, stall_a, stall_b, stall_c}, 32'd0);
  endtask

  // Window table: address, selected for the 0x08000 window, offset, selected for 0x08020.
  logic [AW-1:0] v_addr  [6] = '{20'h08000, 20'h0801F, 20'h07FFF, 20'h08020, 20'h0803F, 20'h18005};
  logic          v_sel   [6] = '{1'b1,      1'b1,      1'b0,      1'b0,      1'b0,      1'b0};
  logic [RW-1:0] v_off   [6] = '{5'h00,     5'h1F,     5'h1F,     5'h00,     5'h1F,     5'h05};
  logic          v_sel_c [6] = '{1'b0,      1'b0,      1'b0,      1'b1,      1'b1,      1'b0};

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst  = 1'b1;
    addr = 20'h00000;
    cyc  = 1'b0;
    stb  = 1'b0;

    // Before any clock edge, ack comes from the power-up value.
    #1;
    check_ack("powerup", 1'b0);
    tick();
    check_ack("reset", 1'b0);
    rst = 1'b0;
    tick();

    // Address-window compare and offset, with no bus cycle active.
    for (int i = 0; i < 6; i++) begin
      addr = v_addr[i];
      #1;
      check($sformatf("win%0d_sel_a", i), {31'd0, sel_a}, {31'd0, v_sel[i]});
      check($sformatf("win%0d_sel_b", i), {31'd0, sel_b}, {31'd0, v_sel[i]});
      check($sformatf("win%0d_sel_c", i), {31'd0, sel_c}, {31'd0, v_sel_c[i]});
      check($sformatf("win%0d_off", i), {27'd0, off_a}, {27'd0, v_off[i]});
      check($sformatf("win%0d_off_b", i), {27'd0, off_b}, {27'd0, v_off[i]});
      check($sformatf("win%0d_excl", i), {31'd0, sel_a & sel_c}, 32'd0);
      check($sformatf("win%0d_req", i), {30'd0, req_a, req_c}, 32'd0);
    end

    // A single request produces exactly one ack pulse, on the next cycle.
    tick();
    addr = 20'h08011; cyc = 1'b1; stb = 1'b1;
    #1;
    check("single_req", {31'd0, req_a}, 32'd1);
    check("single_req_b", {31'd0, req_b}, 32'd1);
    check("single_req_c", {31'd0, req_c}, 32'd0);
    check_ack("single_pre", 1'b0);
    tick();
    cyc = 1'b0; stb = 1'b0;
    check_ack("single_ack", 1'b1);
    tick();
    check_ack("single_after", 1'b0);

    // A cycle without a strobe must not produce a request.
    cyc = 1'b1; stb = 1'b0;
    #1;
    check("nostb_req", {31'd0, req_a}, 32'd0);
    tick();
    check_ack("nostb", 1'b0);
    // A strobe without a cycle must not produce a request either.
    cyc = 1'b0; stb = 1'b1;
    #1;
    check("nocyc_req", {31'd0, req_a}, 32'd0);
    tick();
    check_ack("nocyc", 1'b0);

    // Back-to-back strobes: 0x08000, 0x08001, then 0x09000 (outside the window).
    addr = 20'h08000; cyc = 1'b1; stb = 1'b1;
    tick();
    check_ack("b2b0", 1'b1);
    addr = 20'h08001;
    #1;
    check("b2b1_off", {27'd0, off_a}, 32'd1);
    tick();
    check_ack("b2b1", 1'b1);
    addr = 20'h09000;
    #1;
    check("b2b2_req", {31'd0, req_a}, 32'd0);
    tick();
    check_ack("b2b2", 1'b0);
    cyc = 1'b0; stb = 1'b0;

    // A request that arrives together with reset is dropped. The decode outputs
    // still follow the inputs during reset.
    rst = 1'b1; addr = 20'h08011; cyc = 1'b1; stb = 1'b1;
    #1;
    check("rst_req_comb", {31'd0, req_a}, 32'd1);
    check("rst_sel_comb", {31'd0, sel_a}, 32'd1);
    tick();
    check_ack("rst_drop", 1'b0);
    rst = 1'b0;
    tick();
    check_ack("rst_release", 1'b1);
    cyc = 1'b0; stb = 1'b0;
    tick();
    check_ack("rst_final", 1'b0);

    // A request in the 0x08020 window must be answered by that decoder only.
    addr = 20'h0803C; cyc = 1'b1; stb = 1'b1;
    #1;
    check("c_req", {30'd0, req_a, req_c}, 32'd1);
    tick();
    cyc = 1'b0; stb = 1'b0;
    check("c_ack", {29'd0, ack_a, ack_b, ack_c}, 32'd1);
    tick();
    check("c_ack_after", {29'd0, ack_a, ack_b, ack_c}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
